header_ring_buffer: RTL and testbench

- Multi-event circular header buffer. Successor to the single-image header dual-port RAM.
- Write side stores variable-length header events word by word and commits each event on its last word.
- Read side streams committed events out in order, one word per clock, with framing flags.
- Adds over the previous block: event-length FIFO, occupancy tracking, full/overflow handling with event rollback, and a read sequencer. Sits between the header builder and the DMB/VME readout mux.

---
 rtl/header_ring_buffer.sv | 177 +++++++++++++++++
 tb/tb_header_ring_buffer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/header_ring_buffer.sv
// ============================================================================
// header_ring_buffer: circular multi-event header store with in-order read sequencer
// Optional parity storage/check: HDR_RING_PARITY_EN            Rev 1.0
// ============================================================================
`default_nettype none

module header_ring_buffer #(
  parameter int RAM_WIDTH = 18,
  parameter int RAM_ADRB  = 11,
  parameter int EVT_ADRB  = 4
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 wr_en,
  input  logic [RAM_WIDTH-1:0] wr_data,
  input  logic                 wr_last,
  output logic                 wr_ready,
  input  logic                 rd_start,
  output logic                 rd_busy,
  output logic                 rd_valid,
  output logic                 rd_first,
  output logic                 rd_last,
  output logic [RAM_WIDTH-1:0] rd_data,
  output logic [EVT_ADRB:0]    evt_count,
  output logic [RAM_ADRB:0]    words_used,
`ifdef HDR_RING_PARITY_EN
  output logic                 rd_perr,
`endif
  output logic                 ovf
);

  localparam int DEPTH = 2 ** RAM_ADRB;
  localparam int EVTS  = 2 ** EVT_ADRB;
`ifdef HDR_RING_PARITY_EN
  localparam int MEM_W = RAM_WIDTH + 1;
`else
  localparam int MEM_W = RAM_WIDTH;
`endif
  localparam logic [RAM_ADRB:0] ONE = (RAM_ADRB + 1)'(1);

  typedef enum logic [1:0] {IDLE = 2'd0, STREAM = 2'd1, DRAIN = 2'd2} state_t;

  logic [MEM_W-1:0]    mem      [DEPTH];
  logic [RAM_ADRB:0]   len_fifo [EVTS];

  state_t              state, state_nx;
  logic [RAM_ADRB-1:0] wr_ptr, evt_base, rd_ptr;
  logic [RAM_ADRB:0]   wip_cnt, rd_cnt, rd_len;
  logic [EVT_ADRB-1:0] lf_wp, lf_rp;
  logic [EVT_ADRB:0]   evt_load;
  logic                discard, ovf_q, first_pend, ram_re;
  logic                reading, accept, overflow_hit, commit, pop, rel_evt;
  logic [MEM_W-1:0]    wr_word, rd_word;

`ifdef HDR_RING_PARITY_EN
  logic perr_seen;
  assign wr_word = {^wr_data, wr_data};
  assign ovf     = ovf_q | perr_seen;
`else
  assign wr_word = wr_data;
  assign ovf     = ovf_q;
`endif

  // An event being streamed still holds its words, so it counts against the event limit
  assign reading      = (state != IDLE);
  assign evt_load     = evt_count + {{EVT_ADRB{1'b0}}, reading};
  assign wr_ready     = !words_used[RAM_ADRB] && !evt_load[EVT_ADRB];
  assign accept       = wr_en && wr_ready && !discard;
  assign overflow_hit = wr_en && !wr_ready && !discard;
  assign commit       = accept && wr_last;
  assign pop          = (state == IDLE) && rd_start && (evt_count != '0);
  assign rel_evt      = (state == DRAIN);
  assign rd_busy      = reading;
  assign rd_word      = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (accept) mem[wr_ptr] <= wr_word;
    if (commit) len_fifo[lf_wp] <= wip_cnt + 1'b1;
  end

  always_comb begin
    state_nx = state;
    ram_re   = 1'b0;
    case (state)
      IDLE:    if (pop) state_nx = STREAM;
      STREAM: begin
        ram_re = 1'b1;
        if (rd_cnt == ONE) state_nx = DRAIN;
      end
      DRAIN:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      evt_base   <= '0;
      rd_ptr     <= '0;
      wip_cnt    <= '0;
      rd_cnt     <= '0;
      rd_len     <= '0;
      lf_wp      <= '0;
      lf_rp      <= '0;
      evt_count  <= '0;
      words_used <= '0;
      discard    <= 1'b0;
      ovf_q      <= 1'b0;
      first_pend <= 1'b0;
    end else begin
      state <= state_nx;

      if (accept) begin
        wr_ptr  <= wr_ptr + 1'b1;
        if (wip_cnt == '0) evt_base <= wr_ptr;
        wip_cnt <= wr_last ? '0 : wip_cnt + 1'b1;
      end else if (overflow_hit) begin
        // Drop the whole partial event; stay discarding until its wr_last arrives
        ovf_q   <= 1'b1;
        if (wip_cnt != '0) wr_ptr <= evt_base;
        wip_cnt <= '0;
        discard <= !wr_last;
      end
      if (discard && wr_en && wr_last) discard <= 1'b0;

      if (commit) lf_wp <= lf_wp + 1'b1;
      if (pop) begin
        lf_rp      <= lf_rp + 1'b1;
        rd_cnt     <= len_fifo[lf_rp];
        rd_len     <= len_fifo[lf_rp];
        first_pend <= 1'b1;
      end
      if (ram_re) begin
        rd_ptr     <= rd_ptr + 1'b1;
        rd_cnt     <= rd_cnt - 1'b1;
        first_pend <= 1'b0;
      end

      case ({commit, pop})
        2'b10:   evt_count <= evt_count + 1'b1;
        2'b01:   evt_count <= evt_count - 1'b1;
        default: evt_count <= evt_count;
      endcase

      words_used <= words_used + {{RAM_ADRB{1'b0}}, accept}
                  - (rel_evt ? rd_len : '0)
                  - (overflow_hit ? wip_cnt : '0);
    end
  end

  // Registered RAM output stage; DRAIN covers the cycle this register holds the last word
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rd_valid  <= 1'b0;
      rd_first  <= 1'b0;
      rd_last   <= 1'b0;
      rd_data   <= '0;
`ifdef HDR_RING_PARITY_EN
      rd_perr   <= 1'b0;
      perr_seen <= 1'b0;
`endif
    end else begin
      rd_valid <= ram_re;
      rd_first <= ram_re && first_pend;
      rd_last  <= ram_re && (rd_cnt == ONE);
      if (ram_re) rd_data <= rd_word[RAM_WIDTH-1:0];
`ifdef HDR_RING_PARITY_EN
      rd_perr <= ram_re && (^rd_word);
      if (ram_re && (^rd_word)) perr_seen <= 1'b1;
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_header_ring_buffer.sv
// Directed bench for header_ring_buffer: scoreboard of committed words checked at rd_valid.
`default_nettype none

module tb_header_ring_buffer;

  localparam int RAM_WIDTH = 18;
  localparam int RAM_ADRB  = 4;
  localparam int EVT_ADRB  = 2;

  logic                 clock, reset_n;
  logic                 wr_en, wr_last, wr_ready, rd_start;
  logic [RAM_WIDTH-1:0] wr_data, rd_data;
  logic                 rd_busy, rd_valid, rd_first, rd_last, ovf;
  logic [EVT_ADRB:0]    evt_count;
  logic [RAM_ADRB:0]    words_used;
`ifdef HDR_RING_PARITY_EN
  logic                 rd_perr;
`endif

  int total = 0;
  int bad   = 0;
  logic [RAM_WIDTH+1:0] sb [$];
  logic [RAM_WIDTH+1:0] exp_word;

  header_ring_buffer #(
    .RAM_WIDTH(RAM_WIDTH),
    .RAM_ADRB (RAM_ADRB),
    .EVT_ADRB (EVT_ADRB)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .wr_last   (wr_last),
    .wr_ready  (wr_ready),
    .rd_start  (rd_start),
    .rd_busy   (rd_busy),
    .rd_valid  (rd_valid),
    .rd_first  (rd_first),
    .rd_last   (rd_last),
    .rd_data   (rd_data),
    .evt_count (evt_count),
    .words_used(words_used),
`ifdef HDR_RING_PARITY_EN
    .rd_perr   (rd_perr),
`endif
    .ovf       (ovf)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic cyc();
    @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output word checker: every rd_valid word must match the oldest expected entry
  always @(negedge clock) begin
    if (rd_valid) begin
      total++;
      assert (sb.size() > 0) else begin
        bad++;
        $error("FAIL rd_unexpected: observed=%0h expected=none", rd_data);
      end
      if (sb.size() > 0) begin
        exp_word = sb.pop_front();
        total++;
        assert ({rd_first, rd_last, rd_data} === exp_word) else begin
          bad++;
          $error("FAIL rd_word: observed=%0h expected=%0h", {rd_first, rd_last, rd_data}, exp_word);
        end
      end
    end
  end

  task automatic wr_evt(input int n, input int base, input bit commit);
    for (int i = 0; i < n; i++) begin
      wr_en   = 1'b1;
      wr_data = RAM_WIDTH'(base + i);
      wr_last = (i == n - 1);
      if (commit) sb.push_back({(i == 0), (i == n - 1), RAM_WIDTH'(base + i)});
      cyc();
    end
    wr_en   = 1'b0;
    wr_last = 1'b0;
  endtask

  task automatic read_evt(input int len);
    rd_start = 1'b1;
    cyc();
    rd_start = 1'b0;
    chk("rd_lat1_valid", 32'(rd_valid), 0);
    chk("rd_lat1_busy", 32'(rd_busy), 1);
    cyc();
    for (int i = 0; i < len; i++) begin
      chk("rd_valid_run", 32'(rd_valid), 1);
      cyc();
    end
    chk("rd_valid_end", 32'(rd_valid), 0);
    chk("rd_busy_end", 32'(rd_busy), 0);
  endtask

  initial begin
    reset_n  = 1'b0;
    wr_en    = 1'b0;
    wr_last  = 1'b0;
    wr_data  = '0;
    rd_start = 1'b0;
    repeat (3) cyc();
    chk("rst_valid", 32'(rd_valid), 0);
    chk("rst_data", 32'(rd_data), 0);
    chk("rst_busy", 32'(rd_busy), 0);
    chk("rst_evt", 32'(evt_count), 0);
    chk("rst_used", 32'(words_used), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_ready", 32'(wr_ready), 1);
    reset_n = 1'b1;
    cyc();

    // Single 3-word event
    wr_en = 1'b1; wr_last = 1'b0; wr_data = 18'h00011;
    sb.push_back({1'b1, 1'b0, 18'h00011});
    cyc();
    wr_data = 18'h00022;
    sb.push_back({1'b0, 1'b0, 18'h00022});
    cyc();
    wr_data = 18'h00033; wr_last = 1'b1;
    sb.push_back({1'b0, 1'b1, 18'h00033});
    cyc();
    wr_en = 1'b0; wr_last = 1'b0;
    chk("t1_evt", 32'(evt_count), 1);
    chk("t1_used", 32'(words_used), 3);
    read_evt(3);
    chk("t1_used_after", 32'(words_used), 0);
    chk("t1_evt_after", 32'(evt_count), 0);

    // Repeated 5-word events wrap both pointers across 15->0
    for (int k = 0; k < 7; k++) begin
      wr_evt(5, 'h100 + k * 16, 1'b1);
      chk("wrap_used", 32'(words_used), 5);
      chk("wrap_evt", 32'(evt_count), 1);
      read_evt(5);
      chk("wrap_used_after", 32'(words_used), 0);
    end

    // Full RAM: 12 committed, then an 8-word event overflows at word 5
    wr_evt(12, 'h200, 1'b1);
    chk("full_used12", 32'(words_used), 12);
    chk("full_ready12", 32'(wr_ready), 1);
    for (int i = 0; i < 8; i++) begin
      if (i <= 4) chk("full_ready", 32'(wr_ready), (i < 4) ? 1 : 0);
      wr_en   = 1'b1;
      wr_data = RAM_WIDTH'('h300 + i);
      wr_last = (i == 7);
      cyc();
      if (i == 3) chk("full_used16", 32'(words_used), 16);
      if (i == 4) begin
        chk("ovf_set", 32'(ovf), 1);
        chk("ovf_rewind", 32'(words_used), 12);
      end
    end
    wr_en = 1'b0; wr_last = 1'b0;
    chk("ovf_discard_used", 32'(words_used), 12);
    chk("ovf_evt", 32'(evt_count), 1);
    read_evt(12);
    wr_evt(2, 'h400, 1'b1);
    chk("post_ovf_evt", 32'(evt_count), 1);
    chk("post_ovf_used", 32'(words_used), 2);
    read_evt(2);
    chk("ovf_sticky", 32'(ovf), 1);

    // Event FIFO full with four 1-word events
    reset_n = 1'b0;
    cyc();
    reset_n = 1'b1;
    chk("rst2_ovf", 32'(ovf), 0);
    for (int i = 0; i < 4; i++) wr_evt(1, 'h500 + i, 1'b1);
    chk("efull_ready", 32'(wr_ready), 0);
    chk("efull_used", 32'(words_used), 4);
    chk("efull_evt", 32'(evt_count), 4);
    wr_evt(1, 'h5FF, 1'b0);
    chk("efull_ovf", 32'(ovf), 1);
    chk("efull_used5", 32'(words_used), 4);
    chk("efull_evt5", 32'(evt_count), 4);
    read_evt(1);
    chk("efull_ready_after", 32'(wr_ready), 1);
    for (int i = 0; i < 3; i++) read_evt(1);
    chk("efull_drained", 32'(words_used), 0);

    // Commit B on A's rd_last cycle, then pop B while committing C
    wr_evt(3, 'h600, 1'b1);
    rd_start = 1'b1;
    cyc();
    rd_start = 1'b0;
    cyc();
    cyc();
    wr_en = 1'b1; wr_data = 18'h00700; wr_last = 1'b0;
    sb.push_back({1'b1, 1'b0, 18'h00700});
    cyc();
    chk("sim_a_last", 32'(rd_last), 1);
    wr_data = 18'h00701; wr_last = 1'b1;
    sb.push_back({1'b0, 1'b1, 18'h00701});
    cyc();
    chk("sim_evt_net", 32'(evt_count), 1);
    chk("sim_used_net", 32'(words_used), 2);
    rd_start = 1'b1;
    wr_data  = 18'h00800;
    sb.push_back({1'b1, 1'b1, 18'h00800});
    cyc();
    rd_start = 1'b0; wr_en = 1'b0; wr_last = 1'b0;
    chk("sim_evt_pop_commit", 32'(evt_count), 1);
    chk("sim_used3", 32'(words_used), 3);
    chk("sim_busy", 32'(rd_busy), 1);
    repeat (3) cyc();
    chk("sim_b_done_used", 32'(words_used), 1);
    chk("sim_b_done_busy", 32'(rd_busy), 0);
    read_evt(1);
    chk("sim_used0", 32'(words_used), 0);

    // Reset during STREAM of a 6-word event
    wr_evt(6, 'h900, 1'b1);
    rd_start = 1'b1;
    cyc();
    rd_start = 1'b0;
    cyc();
    cyc();
    reset_n = 1'b0;
    cyc();
    sb.delete();
    chk("mrst_valid", 32'(rd_valid), 0);
    chk("mrst_busy", 32'(rd_busy), 0);
    chk("mrst_evt", 32'(evt_count), 0);
    chk("mrst_used", 32'(words_used), 0);
    chk("mrst_ready", 32'(wr_ready), 1);
    reset_n = 1'b1;
    cyc();

`ifdef HDR_RING_PARITY_EN
    begin
      logic [RAM_WIDTH:0] w;
      wr_evt(1, 'h2AAAA, 1'b1);
      w = dut.mem[0];
      w[RAM_WIDTH] = ~w[RAM_WIDTH];
      dut.mem[0] = w;
      rd_start = 1'b1;
      cyc();
      rd_start = 1'b0;
      cyc();
      chk("perr_valid", 32'(rd_valid), 1);
      chk("perr_pulse", 32'(rd_perr), 1);
      cyc();
      chk("perr_ovf", 32'(ovf), 1);
      cyc();
    end
`endif

    chk("sb_empty", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
